// File: rtl/register_serial_tx_nbit_if.sv
// Handshake and serial-line bundle between a controller and the n-bit serial transmitter.
// Latency: none, wires only.
// Backpressure: the controller may assert load only while ready is high. Loads made while busy are dropped.
interface register_serial_tx_nbit_if #(
    parameter int N = 8
);
    logic [N-1:0] D;
    logic         load;
    logic         ready;
    logic         busy;
    logic         tx;
    logic         done;

    // Controller side: supplies the word and the load request, watches status and the line.
    modport master (
        output D,
        output load,
        input  ready,
        input  busy,
        input  tx,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  D,
        input  load,
        output ready,
        output busy,
        output tx,
        output done
    );
endinterface

// File: rtl/register_serial_tx_nbit.sv
// Parallel-in, serial-out UART-style framer: start bit 0, N data bits LSB first, stop bit 1.
// Latency: tx goes low on the accepting edge; done pulses (N+2)*CLKS_PER_BIT cycles after acceptance.
// Backpressure: ready is low for the whole frame. A load seen while busy is dropped, not queued.
module register_serial_tx_nbit #(
    parameter int N            = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    register_serial_tx_nbit_if.slave bus
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam int BW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [BW-1:0] bit_q, bit_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          period_end;

    // The last cycle of the current bit period.
    assign period_end = (cnt_q == CNT_LAST);

    // Next-state and next-output logic. Every output is computed one cycle ahead,
    // so tx and the status flags leave the block straight from flops.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        ready_d = ready_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
                if (bus.load) begin
                    shift_d = bus.D;
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = START;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            START: begin
                if (period_end) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    bit_d   = '0;
                    tx_d    = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (period_end) begin
                    cnt_d = '0;
                    if (bit_q == BIT_LAST) begin
                        state_d = STOP;
                        bit_d   = '0;
                        tx_d    = 1'b1;
                    end else begin
                        // Shift first so the next data bit is already in position 0 for tx.
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (period_end) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                    ready_d = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset drops any frame in flight and parks the line high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            ready_q <= ready_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.tx    = tx_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
endmodule

// File: tb/tb_register_serial_tx_nbit.sv
// Directed bench for the serial transmitter: an N=8/C=4 instance and an N=1/C=1 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Sample j of a frame is the falling edge that follows rising edge k+j, where k is the accepting edge.
module tb_register_serial_tx_nbit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    register_serial_tx_nbit_if #(.N(8)) b8 ();
    register_serial_tx_nbit_if #(.N(1)) b1 ();

    register_serial_tx_nbit #(.N(8), .CLKS_PER_BIT(4)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (b8)
    );

    register_serial_tx_nbit #(.N(1), .CLKS_PER_BIT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int checks   = 0;
    int failures = 0;

    logic cap_tx    [0:127];
    logic cap_done  [0:127];
    logic cap_ready [0:127];

    // Records the N=8 outputs at n consecutive falling edges, starting with the current one.
    task automatic capture(input int n);
        for (int j = 0; j < n; j++) begin
            cap_tx[j]    = b8.tx;
            cap_done[j]  = b8.done;
            cap_ready[j] = b8.ready;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        b8.D = '0; b8.load = 1'b0;
        b1.D = '0; b1.load = 1'b0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({b8.tx, b8.ready, b8.busy, b8.done} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_n8 got=%b want=1100", {b8.tx, b8.ready, b8.busy, b8.done});
        end
        checks++;
        if ({b1.tx, b1.ready, b1.busy, b1.done} !== 4'b1100) begin
            failures++;
            $display("FAIL reset_n1 got=%b want=1100", {b1.tx, b1.ready, b1.busy, b1.done});
        end
        rst = 1'b1;
        for (int j = 0; j < 20; j++) begin
            @(negedge clk);
            checks++;
            if ({b8.tx, b8.ready, b8.busy, b8.done} !== 4'b1100) begin
                failures++;
                $display("FAIL idle_after_reset cyc=%0d got=%b want=1100", j,
                         {b8.tx, b8.ready, b8.busy, b8.done});
            end
        end
    endtask

    task automatic test_single_frame();
        logic [9:0] exp_f;
        exp_f = 10'b1_1010_0101_0;   // stop, 8'hA5, start
        b8.D = 8'hA5; b8.load = 1'b1;
        @(negedge clk);
        b8.load = 1'b0; b8.D = 8'h00;
        capture(44);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (cap_tx[4*b+2] !== exp_f[b]) begin
                failures++;
                $display("FAIL single_tx bit=%0d got=%b want=%b", b, cap_tx[4*b+2], exp_f[b]);
            end
        end
        for (int j = 0; j < 40; j++) begin
            checks++;
            if (cap_ready[j] !== 1'b0 || cap_done[j] !== 1'b0) begin
                failures++;
                $display("FAIL single_busy cyc=%0d ready=%b done=%b want ready=0 done=0", j,
                         cap_ready[j], cap_done[j]);
            end
        end
        checks++;
        if (cap_done[40] !== 1'b1 || cap_ready[40] !== 1'b1) begin
            failures++;
            $display("FAIL single_done40 done=%b ready=%b want 1 1", cap_done[40], cap_ready[40]);
        end
        checks++;
        if (cap_done[41] !== 1'b0) begin
            failures++;
            $display("FAIL single_done41 got=%b want=0", cap_done[41]);
        end
    endtask

    task automatic test_load_while_busy();
        logic [9:0] exp_f;
        int ndone;
        logic line_idle;
        exp_f = 10'b1_0011_1100_0;   // stop, 8'h3C, start
        b8.D = 8'h3C; b8.load = 1'b1;
        @(negedge clk);
        b8.load = 1'b0;
        for (int j = 0; j < 70; j++) begin
            cap_tx[j] = b8.tx; cap_done[j] = b8.done; cap_ready[j] = b8.ready;
            if (j == 10) begin b8.D = 8'hFF; b8.load = 1'b1; end
            if (j == 11) b8.load = 1'b0;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (cap_tx[4*b+2] !== exp_f[b]) begin
                failures++;
                $display("FAIL busy_tx bit=%0d got=%b want=%b", b, cap_tx[4*b+2], exp_f[b]);
            end
        end
        ndone = 0;
        line_idle = 1'b1;
        for (int j = 0; j < 70; j++) begin
            if (cap_done[j] === 1'b1) ndone++;
            if (j > 40 && cap_tx[j] !== 1'b1) line_idle = 1'b0;
        end
        checks++;
        if (ndone != 1 || cap_done[40] !== 1'b1) begin
            failures++;
            $display("FAIL busy_done count=%0d at40=%b want count=1 at40=1", ndone, cap_done[40]);
        end
        checks++;
        if (line_idle !== 1'b1) begin
            failures++;
            $display("FAIL busy_no_second_frame line_idle=%b want=1", line_idle);
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] exp_a, exp_b;
        int ndone;
        exp_a = 10'b1_0000_0001_0;   // stop, 8'h01, start
        exp_b = 10'b1_1000_0000_0;   // stop, 8'h80, start
        b8.D = 8'h01; b8.load = 1'b1;
        @(negedge clk);
        for (int j = 0; j < 90; j++) begin
            cap_tx[j] = b8.tx; cap_done[j] = b8.done; cap_ready[j] = b8.ready;
            if (j == 1)  b8.D = 8'h80;
            if (j == 41) b8.load = 1'b0;
            @(negedge clk);
        end
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (cap_tx[4*b+2] !== exp_a[b] || cap_tx[41+4*b+2] !== exp_b[b]) begin
                failures++;
                $display("FAIL b2b_tx bit=%0d got=%b/%b want=%b/%b", b,
                         cap_tx[4*b+2], cap_tx[41+4*b+2], exp_a[b], exp_b[b]);
            end
        end
        checks++;
        if (cap_tx[40] !== 1'b1 || cap_ready[40] !== 1'b1 || cap_tx[41] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap tx40=%b ready40=%b tx41=%b want 1 1 0",
                     cap_tx[40], cap_ready[40], cap_tx[41]);
        end
        ndone = 0;
        for (int j = 0; j < 90; j++) if (cap_done[j] === 1'b1) ndone++;
        checks++;
        if (ndone != 2 || cap_done[40] !== 1'b1 || cap_done[81] !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done count=%0d at40=%b at81=%b want 2 1 1",
                     ndone, cap_done[40], cap_done[81]);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] exp_f;
        logic quiet;
        exp_f = 10'b1_0101_0101_0;   // stop, 8'h55, start
        b8.D = 8'h00; b8.load = 1'b1;
        @(negedge clk);
        b8.load = 1'b0;
        repeat (17) @(negedge clk);   // sample 17: middle of data bit 3
        checks++;
        if (b8.tx !== 1'b0 || b8.busy !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_pre tx=%b busy=%b want 0 1", b8.tx, b8.busy);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({b8.tx, b8.ready, b8.busy, b8.done} !== 4'b1100) begin
            failures++;
            $display("FAIL mid_frame_async got=%b want=1100", {b8.tx, b8.ready, b8.busy, b8.done});
        end
        @(negedge clk);
        rst = 1'b1;
        quiet = 1'b1;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            if (b8.done !== 1'b0 || b8.tx !== 1'b1) quiet = 1'b0;
        end
        checks++;
        if (quiet !== 1'b1) begin
            failures++;
            $display("FAIL mid_frame_quiet got=%b want=1", quiet);
        end
        b8.D = 8'h55; b8.load = 1'b1;
        @(negedge clk);
        b8.load = 1'b0;
        capture(44);
        for (int b = 0; b < 10; b++) begin
            checks++;
            if (cap_tx[4*b+2] !== exp_f[b]) begin
                failures++;
                $display("FAIL after_reset_tx bit=%0d got=%b want=%b", b, cap_tx[4*b+2], exp_f[b]);
            end
        end
        checks++;
        if (cap_done[40] !== 1'b1 || cap_done[39] !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_done at39=%b at40=%b want 0 1", cap_done[39], cap_done[40]);
        end
    endtask

    task automatic test_param_corner();
        logic [5:0] t, d, r;
        b1.D = 1'b1; b1.load = 1'b1;
        @(negedge clk);
        b1.load = 1'b0;
        for (int j = 0; j < 6; j++) begin
            t[j] = b1.tx; d[j] = b1.done; r[j] = b1.ready;
            @(negedge clk);
        end
        checks++;
        if (t[2:0] !== 3'b110) begin
            failures++;
            $display("FAIL n1_tx seq(j2..j0)=%b want=110", t[2:0]);
        end
        checks++;
        if (d[4:0] !== 5'b01000) begin
            failures++;
            $display("FAIL n1_done seq(j4..j0)=%b want=01000", d[4:0]);
        end
        checks++;
        if (r[3:0] !== 4'b1000) begin
            failures++;
            $display("FAIL n1_ready seq(j3..j0)=%b want=1000", r[3:0]);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_load_while_busy();
        test_back_to_back();
        test_reset_mid_frame();
        test_param_corner();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/register_serial_tx_nbit.md
Name: register_serial_tx_nbit

Overview:
Parallel-in, serial-out transmitter for n-bit register words; the sending end of the serial link whose receiver deserialises into a load-enabled register bank.
Captures a word on a load handshake and shifts it out as a UART-style frame: one start bit (0), N data bits LSB first, one stop bit (1).
Sits between the register bank and the board serial pin or another FPGA; reports busy/ready/done to the controlling FSM.

Parameters:
N, 8, data word width in bits (N >= 1)
CLKS_PER_BIT, 4, clock cycles per serial bit period (>= 1)

Ports:
clk  input  1  system clock, all state changes on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
D  input  N  parallel word to transmit, sampled only on an accepted load
load  input  1  transmit request, accepted when load=1 and ready=1 at a rising edge
ready  output  1  1 when idle and able to accept load
busy  output  1  1 while a frame is in progress (inverse of ready)
tx  output  1  serial line, idle high, registered
done  output  1  one-cycle pulse when the stop bit period completes

Behaviour:
- Reset (rst=0, asynchronous, takes effect without a clock edge): state IDLE, tx=1, ready=1, busy=0, done=0, shift register=0, bit and cycle counters=0. Reset mid-frame aborts the frame immediately; tx returns high with no partial stop bit.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1, ready=1. On an edge with load=1: capture D into the shift register, clear counters, go to START. With load=0: stay in IDLE.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: tx = shift register bit 0 for CLKS_PER_BIT cycles. At the end of each bit period, shift right by one and increment the bit index. After bit N-1 completes, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and assert done=1 for exactly the first IDLE cycle.
- Timing, with load accepted at edge k:
  - tx=0 from edge k to edge k+C, where C=CLKS_PER_BIT.
  - Data bit i is driven from edge k+(1+i)*C.
  - Stop bit is driven from edge k+(N+1)*C.
  - At edge k+(N+2)*C: ready=1 and done=1.
- All outputs are registered; there is no combinational path from D or load to tx.
- ready and busy change on the accepting edge; ready=0 through START, DATA and STOP.
- load while busy: ignored and not queued. D changes while busy do not affect the frame in flight.
- Back-to-back: load held high continuously gives frames separated by exactly one idle cycle (tx=1), because load is accepted at the edge ending the done cycle. Frame period is (N+2)*C+1 cycles.
- done and load in the same cycle: the new frame is accepted normally, and done still deasserts after one cycle.
- CLKS_PER_BIT=1: one cycle per bit, same state sequence.
- Counter widths: cycle counter is $clog2(CLKS_PER_BIT+1) bits; bit index is $clog2(N+1) bits. Neither counter wraps inside a state; both are cleared on every state change.

Test Plan:
1. Reset then idle (N=8, C=4): hold rst=0 for 3 cycles, release, run 20 cycles with load=0 -> tx=1, ready=1, busy=0, done=0 throughout.
2. Single frame: D=8'hA5, load pulsed 1 cycle -> tx samples at bit centres read 0,1,0,1,0,0,1,0,1,1. done pulses at exactly 40 cycles after acceptance; ready=0 during those 40 cycles.
3. Load while busy: start D=8'h3C, then at cycle 10 pulse load with D=8'hFF -> only 8'h3C is serialised; exactly one done pulse; no second frame.
4. Back-to-back: load held high with D=8'h01, then 8'h80 -> two frames with exactly 1 idle cycle of tx=1 between them; done pulses 41 cycles apart.
5. Reset mid-frame: during data bit 3 of 8'h00, drive rst=0 asynchronously (between edges) -> tx=1 before the next edge, ready=1, no done. Then send 8'h55 -> correct, complete frame.
6. Parameter corner (N=1, C=1): D=1'b1, load pulse -> tx sequence 0,1,1 over 3 cycles; done pulses on cycle 4; ready returns on the same edge.
